// File: rtl/adder_stim_checker_pkg.sv
// Shared types and helpers for the full-adder stimulus/response checker.
// Holds the checker state encoding, the stimulus vector width and the golden response function.
package adder_stim_checker_pkg;

  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Golden {carry, sum}: the three input bits added as a 2-bit number.
  function automatic logic [1:0] exp_resp(input logic [VEC_W-1:0] vec);
    return {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
  endfunction

endpackage

// File: rtl/adder_resp_cmp.sv
// Combinational response comparator for a 1-bit full adder.
// Flags any difference, including X/Z, between the observed and golden {carry, sum}.
module adder_resp_cmp
  import adder_stim_checker_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic sum,
  input  logic carry,
  output logic mismatch
);

  // Case inequality so an unknown response counts as a failure in simulation.
  assign mismatch = ({carry, sum} !== exp_resp({a, b, c}));

endmodule

// File: rtl/adder_stim_checker.sv
// Clocked stimulus generator and response checker for the full-adder interface (BIST use).
// Optional first-failure capture ports are built when ADDER_FIRST_FAIL_EN is defined.
module adder_stim_checker
  import adder_stim_checker_pkg::*;
#(
  parameter int NUM_VECTORS   = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  input  logic                 sum,
  input  logic                 carry,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] vec_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef ADDER_FIRST_FAIL_EN
  ,
  output logic                 first_fail_vld,
  output logic [ERR_CNT_W-1:0] first_fail_vec
`endif
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_DRIVE  = DRIVE;
  localparam logic [1:0] ST_SAMPLE = SAMPLE;
  localparam logic [1:0] ST_DONE   = DONE;

  localparam int               IDX_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]           state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [3:0]           settle_q;
  logic [VEC_W-1:0]     vec_q;
  logic [ERR_CNT_W-1:0] vec_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_nxt;
  logic                 done_q;
  logic                 pass_q;
  logic                 mismatch;
  logic                 start_ok;

  adder_resp_cmp u_cmp (
    .a        (vec_q[2]),
    .b        (vec_q[1]),
    .c        (vec_q[0]),
    .sum      (sum),
    .carry    (carry),
    .mismatch (mismatch)
  );

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);

  // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    err_nxt = err_cnt_q;
    if (mismatch && (err_cnt_q != '1)) err_nxt = err_cnt_q + ERR_CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      settle_q  <= '0;
      vec_q     <= '0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state_q   <= ST_DRIVE;
            idx_q     <= '0;
            settle_q  <= '0;
            vec_q     <= '0;
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q  <= ST_SAMPLE;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        ST_SAMPLE: begin
          err_cnt_q <= err_nxt;
          vec_cnt_q <= vec_cnt_q + ERR_CNT_W'(1);
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_nxt == '0);
          end else begin
            // The 3-bit stimulus register wraps by itself, giving index mod 8.
            idx_q   <= idx_q + IDX_W'(1);
            vec_q   <= vec_q + 3'd1;
            state_q <= ST_DRIVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ADDER_FIRST_FAIL_EN
  logic                 ff_vld_q;
  logic [ERR_CNT_W-1:0] ff_vec_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      ff_vld_q <= 1'b0;
      ff_vec_q <= '0;
    end else if (state_q == ST_SAMPLE && mismatch && !ff_vld_q) begin
      ff_vld_q <= 1'b1;
      ff_vec_q <= vec_cnt_q;
    end
  end

  assign first_fail_vld = ff_vld_q;
  assign first_fail_vec = ff_vec_q;
`endif

  assign {a, b, c} = vec_q;
  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign vec_cnt   = vec_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_adder_stim_checker.sv
// Self-checking bench: a behavioural full adder with per-vector fault masks drives two checker instances.
// Default instance covers table/random/corner runs; a 300-vector instance covers wrap and saturation.
module tb_adder_stim_checker;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, a, b, c, sum, carry, busy, done, pass;
  logic [W-1:0] vec_cnt, err_cnt;
  logic [7:0]   sum_flip, carry_flip;

  logic         rst_w, start_w, a_w, b_w, c_w, sum_w, carry_w, busy_w, done_w, pass_w;
  logic [W-1:0] vec_cnt_w, err_cnt_w;
  logic [7:0]   sum_flip_w, carry_flip_w;

`ifdef ADDER_FIRST_FAIL_EN
  logic         ff_vld, ff_vld_w;
  logic [W-1:0] ff_vec, ff_vec_w;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Adder under test: true arithmetic sum, with chosen output bits flipped per input vector.
  function automatic logic [1:0] model_adder(input logic [2:0] v, input logic [7:0] sf, input logic [7:0] cf);
    int   tot;
    logic s, cy;
    tot = int'(v[2]) + int'(v[1]) + int'(v[0]);
    s   = ((tot % 2) == 1) ^ sf[v];
    cy  = (tot >= 2) ^ cf[v];
    return {cy, s};
  endfunction

  assign {carry, sum}     = model_adder({a, b, c}, sum_flip, carry_flip);
  assign {carry_w, sum_w} = model_adder({a_w, b_w, c_w}, sum_flip_w, carry_flip_w);

  adder_stim_checker #(.NUM_VECTORS(8), .SETTLE_CYCLES(1), .ERR_CNT_W(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt)
`ifdef ADDER_FIRST_FAIL_EN
    , .first_fail_vld(ff_vld), .first_fail_vec(ff_vec)
`endif
  );

  adder_stim_checker #(.NUM_VECTORS(300), .SETTLE_CYCLES(3), .ERR_CNT_W(W)) u_dut_w (
    .clk(clk), .rst(rst_w), .start(start_w), .a(a_w), .b(b_w), .c(c_w), .sum(sum_w), .carry(carry_w),
    .busy(busy_w), .done(done_w), .pass(pass_w), .vec_cnt(vec_cnt_w), .err_cnt(err_cnt_w)
`ifdef ADDER_FIRST_FAIL_EN
    , .first_fail_vld(ff_vld_w), .first_fail_vec(ff_vec_w)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole-run expectation: a vector fails iff its output was corrupted; counters follow their widths.
  function automatic void model_run(input int nv, input logic [7:0] sf, input logic [7:0] cf,
                                    output int errs, output int first, output int vcnt);
    errs  = 0;
    first = -1;
    for (int i = 0; i < nv; i++) begin
      int v;
      v = i % 8;
      if (sf[v] || cf[v]) begin
        if (first < 0) first = i % (1 << W);
        if (errs < (1 << W) - 1) errs++;
      end
    end
    vcnt = nv % (1 << W);
  endfunction

  // Pulse start on the default instance and count edges after the capture edge until done.
  task automatic run_default(output int edges);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy_after_start", busy, 1);
    edges = 0;
    while (!done && edges < 200) begin
      tick();
      edges++;
    end
    check("run_done_seen", done, 1);
  endtask

  typedef struct {
    logic [7:0] sf;
    logic [7:0] cf;
    int         exp_err;
    bit         exp_pass;
    int         exp_ff;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, errs, first, vcnt, bad;

    tbl[0] = '{sf: 8'h00, cf: 8'h00, exp_err: 0, exp_pass: 1'b1, exp_ff: -1};
    tbl[1] = '{sf: 8'h00, cf: 8'hE8, exp_err: 4, exp_pass: 1'b0, exp_ff: 3};  // carry stuck-at-0
    tbl[2] = '{sf: 8'hFF, cf: 8'h00, exp_err: 8, exp_pass: 1'b0, exp_ff: 0};  // inverted sum
    tbl[3] = '{sf: 8'h80, cf: 8'h00, exp_err: 1, exp_pass: 1'b0, exp_ff: 7};
    tbl[4] = '{sf: 8'h04, cf: 8'h24, exp_err: 2, exp_pass: 1'b0, exp_ff: 2};

    rst = 1'b1; start = 1'b0; sum_flip = '0; carry_flip = '0;
    rst_w = 1'b1; start_w = 1'b0; sum_flip_w = '0; carry_flip_w = '0;
    tick();
    tick();
    rst = 1'b0;
    rst_w = 1'b0;
    check("reset_ctrl", {a, b, c, busy, done, pass}, 0);
    check("reset_vec_cnt", vec_cnt, 0);
    check("reset_err_cnt", err_cnt, 0);

    for (int i = 0; i < 5; i++) begin
      sum_flip   = tbl[i].sf;
      carry_flip = tbl[i].cf;
      run_default(edges);
      check($sformatf("tbl%0d_latency", i), edges, 16);
      check($sformatf("tbl%0d_err_cnt", i), err_cnt, tbl[i].exp_err);
      check($sformatf("tbl%0d_pass", i), pass, tbl[i].exp_pass);
      check($sformatf("tbl%0d_vec_cnt", i), vec_cnt, 8);
      check($sformatf("tbl%0d_busy", i), busy, 0);
      check($sformatf("tbl%0d_last_vec", i), {a, b, c}, 7);
`ifdef ADDER_FIRST_FAIL_EN
      check($sformatf("tbl%0d_ff_vld", i), ff_vld, tbl[i].exp_ff >= 0);
      if (tbl[i].exp_ff >= 0) check($sformatf("tbl%0d_ff_vec", i), ff_vec, tbl[i].exp_ff);
`endif
    end

    // Reset at cycle 7 of a failing run clears everything; a clean run follows.
    sum_flip = 8'hFF; carry_flip = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("midrun_err_before_rst", err_cnt, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_rst_ctrl", {a, b, c, busy, done, pass}, 0);
    check("midrun_rst_vec_cnt", vec_cnt, 0);
    check("midrun_rst_err_cnt", err_cnt, 0);
    tick();
    tick();
    check("midrun_stays_idle", {busy, done}, 0);
    sum_flip = '0;
    run_default(edges);
    check("after_rst_latency", edges, 16);
    check("after_rst_pass", pass, 1);
    check("after_rst_err_cnt", err_cnt, 0);

    // A start pulse while busy is ignored; the run still completes 16 edges after the first start.
    carry_flip = 8'hE8;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      edges++;
    end
    start = 1'b1;
    tick();
    edges++;
    start = 1'b0;
    while (!done && edges < 200) begin
      tick();
      edges++;
    end
    check("busy_start_latency", edges, 16);
    check("busy_start_err_cnt", err_cnt, 4);
    check("busy_start_vec_cnt", vec_cnt, 8);

    // Reset and start together: reset wins and the block stays idle.
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_ctrl", {busy, done, pass}, 0);
    check("rst_start_err_cnt", err_cnt, 0);
    tick();
    tick();
    check("rst_start_idle", {busy, done, a, b, c}, 0);

    // Randomized fault masks against the run-level model.
    for (int r = 0; r < 6; r++) begin
      sum_flip   = 8'($urandom);
      carry_flip = 8'($urandom) & 8'($urandom);
      model_run(8, sum_flip, carry_flip, errs, first, vcnt);
      run_default(edges);
      check($sformatf("rand%0d_latency", r), edges, 16);
      check($sformatf("rand%0d_err_cnt", r), err_cnt, errs);
      check($sformatf("rand%0d_pass", r), pass, errs == 0);
      check($sformatf("rand%0d_vec_cnt", r), vec_cnt, vcnt);
`ifdef ADDER_FIRST_FAIL_EN
      check($sformatf("rand%0d_ff_vld", r), ff_vld, first >= 0);
      if (first >= 0) check($sformatf("rand%0d_ff_vec", r), ff_vec, first);
`endif
    end

    // 300 vectors, 3 settle cycles: stimulus wraps mod 8, err_cnt saturates, done at edge 1200.
    for (int run = 0; run < 2; run++) begin
      sum_flip_w   = (run == 0) ? 8'h00 : 8'hFF;
      carry_flip_w = (run == 0) ? 8'hE8 : 8'h00;
      start_w = 1'b1;
      tick();
      start_w = 1'b0;
      edges = 0;
      bad   = 0;
      while (!done_w && edges < 2000) begin
        if (int'({a_w, b_w, c_w}) != (edges / 4) % 8) bad++;
        tick();
        edges++;
      end
      check($sformatf("wide%0d_stim_wrap_errors", run), bad, 0);
      check($sformatf("wide%0d_latency", run), edges, 1200);
      check($sformatf("wide%0d_err_cnt", run), err_cnt_w, (run == 0) ? 149 : 255);
      check($sformatf("wide%0d_pass", run), pass_w, 0);
      check($sformatf("wide%0d_vec_cnt", run), vec_cnt_w, 44);
      check($sformatf("wide%0d_last_vec", run), {a_w, b_w, c_w}, 3);
`ifdef ADDER_FIRST_FAIL_EN
      check($sformatf("wide%0d_ff_vec", run), ff_vec_w, (run == 0) ? 3 : 0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
